// File: rtl/zbt_arbiter_if.sv
// Request/response and ZBT bus bundle shared by the arbiter and its requesters.
// slave = arbiter side, master = requesters plus SRAM model side.
interface zbt_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36
) ();
  logic              vga_flag;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_pixel;
  logic              done_vga;

  logic              ntsc_flag;
  logic [ADDR_W-1:0] ntsc_addr;
  logic [DATA_W-1:0] ntsc_data;
  logic              done_ntsc;

  logic              proc_flag;
  logic              proc_we;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic [DATA_W-1:0] proc_rdata;
  logic              done_proc;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [2:0]        overrun;

  modport slave (
    input  vga_flag, vga_addr, ntsc_flag, ntsc_addr, ntsc_data,
           proc_flag, proc_we, proc_addr, proc_wdata, mem_rdata,
    output vga_pixel, done_vga, done_ntsc, proc_rdata, done_proc,
           mem_addr, mem_we, mem_wdata, overrun
  );

  modport master (
    output vga_flag, vga_addr, ntsc_flag, ntsc_addr, ntsc_data,
           proc_flag, proc_we, proc_addr, proc_wdata, mem_rdata,
    input  vga_pixel, done_vga, done_ntsc, proc_rdata, done_proc,
           mem_addr, mem_we, mem_wdata, overrun
  );
endinterface

// File: rtl/zbt_arbiter.sv
// Three-way ZBT SRAM port arbiter (vga read, ntsc write, proc read/write) with
// starvation relief for proc and a fixed-latency tag pipeline for read returns.
module zbt_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 36,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 8
) (
  input logic          clock,
  input logic          reset,
  zbt_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] ID_VGA  = 2'd0;
  localparam logic [1:0] ID_NTSC = 2'd1;
  localparam logic [1:0] ID_PROC = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } tag_t;

  logic [2:0]        pend_q, pend_d;
  logic [2:0]        overrun_q, overrun_d;
  logic [2:0]        grant_s;
  logic [2:0]        flags_s;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] vga_addr_q, vga_addr_d;
  logic [ADDR_W-1:0] ntsc_addr_q, ntsc_addr_d;
  logic [DATA_W-1:0] ntsc_data_q, ntsc_data_d;
  logic              proc_we_q, proc_we_d;
  logic [ADDR_W-1:0] proc_addr_q, proc_addr_d;
  logic [DATA_W-1:0] proc_wdata_q, proc_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  tag_t              new_tag_s;
  tag_t              out_tag_s;
  tag_t [READ_LAT:0] tag_q, tag_d;
  logic [DATA_W-1:0] vga_pixel_q, vga_pixel_d;
  logic [DATA_W-1:0] proc_rdata_q, proc_rdata_d;
  logic              done_vga_q, done_vga_d;
  logic              done_ntsc_q, done_ntsc_d;
  logic              done_proc_q, done_proc_d;

  assign flags_s = {bus.proc_flag, bus.ntsc_flag, bus.vga_flag};

  // Fixed priority vga > ntsc > proc; a starved proc jumps ahead of ntsc only.
  always_comb begin
    grant_s = 3'b000;
    if (pend_q[0]) begin
      grant_s = 3'b001;
    end else if (pend_q[2] && (starve_q >= CNT_W'(STARVE_MAX))) begin
      grant_s = 3'b100;
    end else if (pend_q[1]) begin
      grant_s = 3'b010;
    end else if (pend_q[2]) begin
      grant_s = 3'b100;
    end else begin
      grant_s = 3'b000;
    end
  end

  // A flag landing on its own grant edge is a fresh request, not an overrun.
  always_comb begin
    pend_d       = (pend_q & ~grant_s) | flags_s;
    overrun_d    = overrun_q | (flags_s & pend_q & ~grant_s);
    vga_addr_d   = bus.vga_flag  ? bus.vga_addr   : vga_addr_q;
    ntsc_addr_d  = bus.ntsc_flag ? bus.ntsc_addr  : ntsc_addr_q;
    ntsc_data_d  = bus.ntsc_flag ? bus.ntsc_data  : ntsc_data_q;
    proc_we_d    = bus.proc_flag ? bus.proc_we    : proc_we_q;
    proc_addr_d  = bus.proc_flag ? bus.proc_addr  : proc_addr_q;
    proc_wdata_d = bus.proc_flag ? bus.proc_wdata : proc_wdata_q;
    if (pend_q[2] && !grant_s[2]) begin
      starve_d = (starve_q == CNT_W'(STARVE_MAX)) ? starve_q : starve_q + CNT_W'(1);
    end else begin
      starve_d = '0;
    end
  end

  always_comb begin
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_we_d        = 1'b0;
    new_tag_s       = '0;
    case (grant_s)
      3'b001: begin
        mem_addr_d      = vga_addr_q;
        new_tag_s.valid = 1'b1;
        new_tag_s.id    = ID_VGA;
      end
      3'b010: begin
        mem_addr_d   = ntsc_addr_q;
        mem_wdata_d  = ntsc_data_q;
        mem_we_d     = 1'b1;
        new_tag_s.id = ID_NTSC;
      end
      3'b100: begin
        mem_addr_d      = proc_addr_q;
        mem_we_d        = proc_we_q;
        mem_wdata_d     = proc_we_q ? proc_wdata_q : mem_wdata_q;
        new_tag_s.valid = ~proc_we_q;
        new_tag_s.id    = ID_PROC;
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase
    tag_d[0] = new_tag_s;
    for (int i = 1; i <= READ_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // The oldest tag lines up with mem_rdata for the address issued READ_LAT cycles ago.
  always_comb begin
    out_tag_s    = tag_q[READ_LAT];
    done_vga_d   = out_tag_s.valid && (out_tag_s.id == ID_VGA);
    vga_pixel_d  = done_vga_d ? bus.mem_rdata : vga_pixel_q;
    done_ntsc_d  = grant_s[1];
    if (out_tag_s.valid && (out_tag_s.id == ID_PROC)) begin
      proc_rdata_d = bus.mem_rdata;
      done_proc_d  = 1'b1;
    end else begin
      proc_rdata_d = proc_rdata_q;
      done_proc_d  = grant_s[2] & proc_we_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q       <= '0;
      overrun_q    <= '0;
      starve_q     <= '0;
      vga_addr_q   <= '0;
      ntsc_addr_q  <= '0;
      ntsc_data_q  <= '0;
      proc_we_q    <= 1'b0;
      proc_addr_q  <= '0;
      proc_wdata_q <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      tag_q        <= '0;
      vga_pixel_q  <= '0;
      proc_rdata_q <= '0;
      done_vga_q   <= 1'b0;
      done_ntsc_q  <= 1'b0;
      done_proc_q  <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      overrun_q    <= overrun_d;
      starve_q     <= starve_d;
      vga_addr_q   <= vga_addr_d;
      ntsc_addr_q  <= ntsc_addr_d;
      ntsc_data_q  <= ntsc_data_d;
      proc_we_q    <= proc_we_d;
      proc_addr_q  <= proc_addr_d;
      proc_wdata_q <= proc_wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      tag_q        <= tag_d;
      vga_pixel_q  <= vga_pixel_d;
      proc_rdata_q <= proc_rdata_d;
      done_vga_q   <= done_vga_d;
      done_ntsc_q  <= done_ntsc_d;
      done_proc_q  <= done_proc_d;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.vga_pixel  = vga_pixel_q;
  assign bus.proc_rdata = proc_rdata_q;
  assign bus.done_vga   = done_vga_q;
  assign bus.done_ntsc  = done_ntsc_q;
  assign bus.done_proc  = done_proc_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_zbt_arbiter.sv
// Directed-vector bench for zbt_arbiter with a two-stage ZBT read model.
module tb_zbt_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  zbt_arbiter_if #(.ADDR_W(19), .DATA_W(36)) bus ();

  zbt_arbiter #(.ADDR_W(19), .DATA_W(36), .READ_LAT(2), .STARVE_MAX(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Unwritten locations return a fixed per-address pattern.
  function automatic logic [35:0] dw(input logic [7:0] a);
    if (a == 8'h10) return 36'h123456789;
    return {28'hABCD000, a};
  endfunction

  logic [35:0] mem_model [0:255];
  logic [255:0] written;
  logic [35:0] rd1, rd2;
  logic [7:0]  ma;
  assign ma = bus.mem_addr[7:0];
  assign bus.mem_rdata = rd2;

  always @(posedge clock) begin
    if (reset) begin
      written <= '0;
    end else if (bus.mem_we) begin
      written[ma]   <= 1'b1;
      mem_model[ma] <= bus.mem_wdata;
    end
    rd1 <= written[ma] ? mem_model[ma] : dw(ma);
    rd2 <= rd1;
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.vga_flag   = 1'b0; bus.vga_addr   = '0;
    bus.ntsc_flag  = 1'b0; bus.ntsc_addr  = '0; bus.ntsc_data = '0;
    bus.proc_flag  = 1'b0; bus.proc_we    = 1'b0;
    bus.proc_addr  = '0;   bus.proc_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int issue;
    // reset state
    do_reset();
    check_vec("rst_mem_addr",   bus.mem_addr,   64'h0);
    check_vec("rst_mem_we",     bus.mem_we,     64'h0);
    check_vec("rst_mem_wdata",  bus.mem_wdata,  64'h0);
    check_vec("rst_vga_pixel",  bus.vga_pixel,  64'h0);
    check_vec("rst_proc_rdata", bus.proc_rdata, 64'h0);
    check_vec("rst_dones", {bus.done_vga, bus.done_ntsc, bus.done_proc}, 64'h0);
    check_vec("rst_overrun",    bus.overrun,    64'h0);

    // reset with a vga read in flight
    bus.vga_flag = 1'b1; bus.vga_addr = 19'h00010;
    step();
    bus.vga_flag = 1'b0;
    step();
    check_vec("inflight_issue", bus.mem_addr, 64'h10);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_vec("inflight_rst_addr", bus.mem_addr, 64'h0);
    check_vec("inflight_rst_ovr",  bus.overrun,  64'h0);
    for (int t = 0; t < 6; t++) begin
      step();
      check_vec("inflight_no_done", bus.done_vga, 64'h0);
    end

    // single vga read
    do_reset();
    bus.vga_flag = 1'b1; bus.vga_addr = 19'h00010;
    step();
    bus.vga_flag = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      step();
      if (t == 1) begin
        check_vec("vga1_addr", bus.mem_addr, 64'h10);
        check_vec("vga1_we",   bus.mem_we,   64'h0);
      end
      check_vec("vga1_done", bus.done_vga, (t == 4) ? 64'h1 : 64'h0);
    end
    check_vec("vga1_pixel", bus.vga_pixel, 64'h123456789);

    // simultaneous requests
    do_reset();
    bus.vga_flag  = 1'b1; bus.vga_addr  = 19'h00020;
    bus.ntsc_flag = 1'b1; bus.ntsc_addr = 19'h00030; bus.ntsc_data = 36'h55;
    bus.proc_flag = 1'b1; bus.proc_we   = 1'b0;      bus.proc_addr = 19'h00040;
    step();
    idle();
    for (int t = 1; t <= 7; t++) begin
      step();
      if (t == 1) begin
        check_vec("sim_e1_addr", bus.mem_addr, 64'h20);
        check_vec("sim_e1_we",   bus.mem_we,   64'h0);
      end else if (t == 2) begin
        check_vec("sim_e2_addr",  bus.mem_addr,  64'h30);
        check_vec("sim_e2_we",    bus.mem_we,    64'h1);
        check_vec("sim_e2_wdata", bus.mem_wdata, 64'h55);
      end else if (t == 3) begin
        check_vec("sim_e3_addr", bus.mem_addr, 64'h40);
        check_vec("sim_e3_we",   bus.mem_we,   64'h0);
      end
      check_vec("sim_done_ntsc", bus.done_ntsc, (t == 2) ? 64'h1 : 64'h0);
      check_vec("sim_done_vga",  bus.done_vga,  (t == 4) ? 64'h1 : 64'h0);
      check_vec("sim_done_proc", bus.done_proc, (t == 6) ? 64'h1 : 64'h0);
    end
    check_vec("sim_vga_pixel",  bus.vga_pixel,  {28'h0, dw(8'h20)});
    check_vec("sim_proc_rdata", bus.proc_rdata, {28'h0, dw(8'h40)});

    // starvation: ntsc every cycle, proc read pending
    do_reset();
    bus.proc_flag = 1'b1; bus.proc_we = 1'b0; bus.proc_addr = 19'h00041;
    bus.ntsc_flag = 1'b1; bus.ntsc_addr = 19'h00080;
    step();
    bus.proc_flag = 1'b0;
    issue = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.ntsc_addr = 19'h00080 + 19'(k);
      step();
      if (issue == 0 && !bus.mem_we && bus.mem_addr == 19'h00041) issue = k;
    end
    idle();
    check_vec("starve_issue_edge", issue, 64'd9);
    check_vec("starve_overrun", bus.overrun, 64'h2);

    // vga every 4th cycle under ntsc flood plus a proc request
    do_reset();
    for (int t = 0; t <= 13; t++) begin
      bus.ntsc_flag = 1'b1; bus.ntsc_addr = 19'h00090 + 19'(t);
      bus.vga_flag  = (t % 4 == 0) && (t <= 8);
      bus.vga_addr  = 19'h00050 + 19'(t);
      bus.proc_flag = (t == 0); bus.proc_we = 1'b0; bus.proc_addr = 19'h00042;
      step();
      check_vec("vga4_done", bus.done_vga,
                (t >= 4 && t <= 12 && t % 4 == 0) ? 64'h1 : 64'h0);
      if (t >= 4 && t <= 12 && t % 4 == 0) begin
        check_vec("vga4_pixel", bus.vga_pixel, {28'h0, dw(8'h50 + 8'(t - 4))});
      end
    end
    idle();
    check_vec("vga4_no_overrun", bus.overrun[0], 64'h0);

    // overrun: ntsc twice while vga holds it off
    do_reset();
    bus.vga_flag  = 1'b1; bus.vga_addr  = 19'h00021;
    bus.ntsc_flag = 1'b1; bus.ntsc_addr = 19'h00060; bus.ntsc_data = 36'h111;
    step();
    bus.vga_addr = 19'h00022; bus.ntsc_data = 36'h222;
    step();
    idle();
    step();
    check_vec("ovr_e2_vga_addr", bus.mem_addr, 64'h22);
    step();
    check_vec("ovr_e3_addr",  bus.mem_addr,  64'h60);
    check_vec("ovr_e3_we",    bus.mem_we,    64'h1);
    check_vec("ovr_e3_wdata", bus.mem_wdata, 64'h222);
    check_vec("ovr_done",     bus.done_ntsc, 64'h1);
    check_vec("ovr_bits",     bus.overrun,   64'h2);
    step();
    check_vec("ovr_mem", mem_model[8'h60], 64'h222);

    // mixed: proc write then read of the same address
    do_reset();
    bus.proc_flag = 1'b1; bus.proc_we = 1'b1;
    bus.proc_addr = 19'h00070; bus.proc_wdata = 36'hCAFE;
    step();
    bus.proc_we = 1'b0;
    step();
    idle();
    check_vec("mix_e1_we",    bus.mem_we,    64'h1);
    check_vec("mix_e1_addr",  bus.mem_addr,  64'h70);
    check_vec("mix_e1_wdata", bus.mem_wdata, 64'hCAFE);
    check_vec("mix_wr_done",  bus.done_proc, 64'h1);
    for (int t = 2; t <= 7; t++) begin
      step();
      if (t == 2) begin
        check_vec("mix_e2_we",   bus.mem_we,   64'h0);
        check_vec("mix_e2_addr", bus.mem_addr, 64'h70);
      end
      check_vec("mix_done_proc", bus.done_proc, (t == 5) ? 64'h1 : 64'h0);
      check_vec("mix_no_vga",    bus.done_vga,  64'h0);
    end
    check_vec("mix_rdata",   bus.proc_rdata, 64'hCAFE);
    check_vec("mix_overrun", bus.overrun,    64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/zbt_arbiter.md
Name: zbt_arbiter

Overview:
- Shares the single ZBT SRAM port between three requesters:
  - VGA reader (pixel fetch for display)
  - NTSC writer (camera frame store)
  - Processing engine (projective transform; reads and writes)
- Flag-pulse handshake: requester pulses a flag with its address/data; the arbiter returns a one-cycle done pulse.
- Fixed priority with starvation relief for the processing port; fixed read latency so the VGA path can use a constant pipeline delay.

Parameters:
- ADDR_W, 19, ZBT word address width
- DATA_W, 36, ZBT word width (two 18-bit YCrCb pixels)
- READ_LAT, 2, cycles from address on bus to mem_rdata valid
- STARVE_MAX, 8, cycles proc may wait before it outranks ntsc

Ports:
- clock  in  1  system clock; everything sampled on rising edge
- reset  in  1  synchronous, active-high
- vga_flag  in  1  one-cycle read request
- vga_addr  in  ADDR_W  read address, sampled with vga_flag
- vga_pixel  out  DATA_W  read data, held until next vga read completes
- done_vga  out  1  one-cycle pulse: vga_pixel updated
- ntsc_flag  in  1  one-cycle write request
- ntsc_addr  in  ADDR_W  write address, sampled with ntsc_flag
- ntsc_data  in  DATA_W  write data, sampled with ntsc_flag
- done_ntsc  out  1  one-cycle pulse: write issued to bus
- proc_flag  in  1  one-cycle request
- proc_we  in  1  1=write, 0=read; sampled with proc_flag
- proc_addr  in  ADDR_W  address
- proc_wdata  in  DATA_W  write data
- proc_rdata  out  DATA_W  read data, held
- done_proc  out  1  one-cycle pulse: write issued / read data valid
- mem_addr  out  ADDR_W  registered ZBT address
- mem_we  out  1  registered write enable, active high
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  ZBT read data
- overrun  out  3  sticky {proc,ntsc,vga}: flag arrived while that requester was still pending

Behaviour:
- **Reset** (synchronous, active-high, dominates everything):
  - Clears all pending bits, the in-flight tag pipeline, the starve counter and overrun.
  - Zeroes every output: mem_addr, mem_we, mem_wdata, vga_pixel, proc_rdata, all done_* pulses.
  - In-flight reads at reset are discarded; no done pulse is produced for them afterwards.
- **Request capture:**
  - A flag high at edge E0 sets that requester's pending bit and latches its addr/data/we.
  - If a flag arrives at the same edge its pending bit is being cleared by a grant, the new request wins: pending stays set and the new fields are latched.
  - If the flag arrives while pending is set and not being cleared at that edge, set the overrun bit. The new fields overwrite the old ones.
- **Arbitration:**
  - Combinational over the pending bits; at most one grant per cycle.
  - Priority is vga > ntsc > proc.
  - Exception: if starve_cnt >= STARVE_MAX, priority is vga > proc > ntsc.
- **Starve counter:**
  - Increments, saturating at STARVE_MAX, each cycle proc is pending and not granted.
  - Clears on proc grant or when proc is not pending.
- **Issue:**
  - At the grant edge E1, mem_addr, mem_we and mem_wdata are registered and the winner's pending bit clears.
  - With no grant, mem_we = 0 and mem_addr/mem_wdata hold their previous values.
- **Writes:** done_ntsc, or done_proc for a proc write, is high for exactly the one cycle following E1.
- **Reads and the tag pipeline:**
  - Each issue pushes a tag {valid, id[1:0]} into a READ_LAT+1 deep shift register; writes push valid=0.
  - At edge E(2+READ_LAT) the tag emerges. mem_rdata is captured into vga_pixel or proc_rdata per id, and the matching done pulse is high for the following cycle.
  - Default VGA latency: vga_flag at E0, done_vga and vga_pixel valid after E4. Four cycles, constant regardless of other traffic.
- **Back-to-back:** one issue per cycle sustained; reads and writes may interleave on consecutive cycles (ZBT, no turnaround).
- **VGA guarantee:** with vga_flag at most 1 in 4 cycles, vga never waits and never sets overrun[0].
- **Done pulses:** done_vga and done_proc can be high in the same cycle only if they come from different issue cycles; each pulse is exactly one cycle.

Test Plan:
- **Reset:** reset high 2 cycles with a vga read in flight -> all outputs 0, no done_vga in the following 6 cycles, overrun = 0.
- **Single vga read:** vga_flag at E0, addr=0x00010; model returns 0x123456789 -> mem_addr=0x00010, mem_we=0 after E1; done_vga high after E4 only; vga_pixel=0x123456789.
- **Simultaneous requests:** vga, ntsc and proc flags all at E0 -> issue order vga (E1), ntsc (E2), proc (E3); done_ntsc after E2; proc read done after E6.
- **Starvation:** ntsc_flag every cycle with proc pending -> proc issued no later than 9 cycles after its flag; vga_flag every 4th cycle still gets done exactly 4 edges after its flag.
- **Overrun:** ntsc_flag twice in consecutive cycles while vga_flag holds ntsc off -> overrun = 3'b010; the written data is the second value.
- **Mixed traffic:** proc write then proc read of the same address on consecutive cycles -> read returns the written data; tags route correctly with no done_vga pulses.
